// File: rtl/pmem_arbiter.sv
// Shares the single physical-memory line port between the icache and dcache.
// One owner at a time; its command is registered and held until mem_resp.
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = icache, 1 = dcache
  logic                last_q, last_d;
  logic                op_read_q, op_read_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic i_req, d_req, win_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  // D wins when alone, or on a tie when I held the most recent grant.
  assign win_d = d_req & (~i_req | ~last_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    op_read_d  = op_read_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d = BUSY;
          owner_d = win_d;
          last_d  = win_d;
          if (win_d) begin
            // A simultaneous read+write from D is forwarded as a write only.
            op_write_d = d_pmem_write;
            op_read_d  = ~d_pmem_write;
            addr_d     = d_pmem_address;
            wdata_d    = d_pmem_wdata;
          end else begin
            op_write_d = 1'b0;
            op_read_d  = 1'b1;
            addr_d     = i_pmem_address;
            wdata_d    = '0;
          end
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d    = IDLE;
          op_read_d  = 1'b0;
          op_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      op_read_q  <= op_read_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign mem_read     = op_read_q;
  assign mem_write    = op_write_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = (state_q == BUSY) & mem_resp & ~owner_q;
  assign d_pmem_resp  = (state_q == BUSY) & mem_resp & owner_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: transaction-level reference model plus directed
// scenarios and a randomized phase.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int d_cnt  = 0;
  int resp_q[$];

  // Reference model: the memory transaction currently in flight, if any.
  bit           m_busy;
  bit           m_owner;
  bit           m_last;
  bit           m_rd, m_wr;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1; m_rd = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_update();
    bit ireq, dreq, win;
    if (!m_busy) begin
      ireq = i_pmem_read;
      dreq = d_pmem_read || d_pmem_write;
      if (ireq || dreq) begin
        win = (ireq && dreq) ? !m_last : dreq;
        m_busy = 1; m_owner = win; m_last = win;
        if (win) begin
          m_wr = d_pmem_write; m_rd = !d_pmem_write;
          m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
        end else begin
          m_rd = 1; m_wr = 0; m_addr = i_pmem_address; m_wdata = '0;
        end
      end
    end else if (mem_resp) begin
      m_busy = 0; m_rd = 0; m_wr = 0;
    end
  endtask

  task automatic check_all();
    chk("mem_read", {255'd0, mem_read}, {255'd0, m_busy && m_rd});
    chk("mem_write", {255'd0, mem_write}, {255'd0, m_busy && m_wr});
    if (m_busy) begin
      chk("mem_address", {224'd0, mem_address}, {224'd0, m_addr});
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("i_pmem_resp", {255'd0, i_pmem_resp}, {255'd0, m_busy && mem_resp && !m_owner});
    chk("d_pmem_resp", {255'd0, d_pmem_resp}, {255'd0, m_busy && mem_resp && m_owner});
    chk("i_pmem_rdata", i_pmem_rdata, mem_rdata);
    chk("d_pmem_rdata", d_pmem_rdata, mem_rdata);
  endtask

  // Entered just after a falling edge with inputs set; returns after the next one.
  task automatic step();
    #1 check_all();
    if (i_pmem_resp) resp_q.push_back(0);
    if (d_pmem_resp) begin resp_q.push_back(1); d_cnt++; end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // From IDLE with requests set: grant, lat busy cycles, then a one-cycle resp.
  task automatic one_xact(int lat, logic [255:0] rd);
    step();
    repeat (lat) step();
    mem_resp = 1; mem_rdata = rd;
    step();
    mem_resp = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] pat_a, pat_b;
    int d_before, lat;
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'hB0B0_CAFE}};

    // Reset held with every request asserted and a stray mem_resp.
    rst = 0;
    i_pmem_read = 1; i_pmem_address = 32'h0000_1040;
    d_pmem_read = 1; d_pmem_write = 0;
    d_pmem_address = 32'h0000_3000; d_pmem_wdata = pat_b;
    mem_rdata = pat_a; mem_resp = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mem_read", {255'd0, mem_read}, 256'd0);
    chk("rst_mem_write", {255'd0, mem_write}, 256'd0);
    chk("rst_mem_address", {224'd0, mem_address}, 256'd0);
    chk("rst_mem_wdata", mem_wdata, 256'd0);
    chk("rst_i_resp", {255'd0, i_pmem_resp}, 256'd0);
    chk("rst_d_resp", {255'd0, d_pmem_resp}, 256'd0);
    @(negedge clk);
    rst = 1; mem_resp = 0;

    // First tie after reset goes to I.
    step();
    #1;
    chk("tie_first_read", {255'd0, mem_read}, 256'd1);
    chk("tie_first_addr", {224'd0, mem_address}, 256'h1040);
    repeat (4) step();
    mem_resp = 1; mem_rdata = pat_a;
    #1;
    chk("i_resp_pulse", {255'd0, i_pmem_resp}, 256'd1);
    chk("i_rdata_A", i_pmem_rdata, pat_a);
    chk("d_resp_quiet", {255'd0, d_pmem_resp}, 256'd0);
    step();
    mem_resp = 0; i_pmem_read = 0;
    #1 chk("idle_after_resp", {255'd0, mem_read}, 256'd0);
    step();
    #1 chk("d_grant_addr", {224'd0, mem_address}, 256'h3000);
    repeat (2) step();
    mem_resp = 1;
    #1 chk("d_resp_pulse", {255'd0, d_pmem_resp}, 256'd1);
    step();
    mem_resp = 0; d_pmem_read = 0;
    step();

    // Lone I read at 0x1040 with 5-cycle memory latency.
    i_pmem_read = 1; i_pmem_address = 32'h0000_1040;
    step();
    #1 chk("lone_i_addr", {224'd0, mem_address}, 256'h1040);
    repeat (5) step();
    mem_resp = 1; mem_rdata = pat_a;
    step();
    mem_resp = 0; i_pmem_read = 0;
    step();

    // Writeback then refill read of the same line.
    d_before = d_cnt;
    d_pmem_write = 1; d_pmem_address = 32'h0000_2000; d_pmem_wdata = pat_b;
    step();
    #1;
    chk("wb_write", {255'd0, mem_write}, 256'd1);
    chk("wb_wdata", mem_wdata, pat_b);
    repeat (3) step();
    mem_resp = 1;
    step();
    mem_resp = 0; d_pmem_write = 0; d_pmem_read = 1;
    #1 chk("wb_gap_idle", {254'd0, mem_read, mem_write}, 256'd0);
    step();
    #1;
    chk("refill_read", {255'd0, mem_read}, 256'd1);
    chk("refill_addr", {224'd0, mem_address}, 256'h2000);
    repeat (2) step();
    mem_resp = 1;
    step();
    mem_resp = 0; d_pmem_read = 0;
    chk("wb_two_resps", 256'(d_cnt - d_before), 256'd2);
    step();

    // Both requesting continuously: round-robin order.
    resp_q.delete();
    i_pmem_read = 1; d_pmem_read = 1;
    for (int t = 0; t < 4; t++) one_xact(t + 1, rnd_line());
    i_pmem_read = 0; d_pmem_read = 0;
    step();
    chk("rr_count", 256'(resp_q.size()), 256'd4);
    if (resp_q.size() == 4) begin
      chk("rr_0", 256'(resp_q[0]), 256'd0);
      chk("rr_1", 256'(resp_q[1]), 256'd1);
      chk("rr_2", 256'(resp_q[2]), 256'd0);
      chk("rr_3", 256'(resp_q[3]), 256'd1);
    end

    // Requester changes its command mid-transaction.
    d_pmem_write = 1; d_pmem_address = 32'h0000_0100;
    step();
    d_pmem_address = 32'h0000_0200; d_pmem_write = 0;
    #1;
    chk("glitch_addr", {224'd0, mem_address}, 256'h100);
    chk("glitch_write", {255'd0, mem_write}, 256'd1);
    repeat (3) step();
    mem_resp = 1;
    step();
    mem_resp = 0;
    step();

    // Asynchronous reset between edges while BUSY.
    i_pmem_read = 1; i_pmem_address = 32'h0000_0440;
    step();
    step();
    i_pmem_read = 0;
    mem_resp = 1;
    #2 rst = 0;
    #1;
    chk("arst_read", {255'd0, mem_read}, 256'd0);
    chk("arst_i_resp", {255'd0, i_pmem_resp}, 256'd0);
    chk("arst_d_resp", {255'd0, d_pmem_resp}, 256'd0);
    model_reset();
    mem_resp = 0;
    d_pmem_read = 1; d_pmem_address = 32'h0000_5540;
    @(negedge clk);
    rst = 1;
    step();
    #1;
    chk("post_arst_read", {255'd0, mem_read}, 256'd1);
    chk("post_arst_addr", {224'd0, mem_address}, 256'h5540);
    step();
    mem_resp = 1;
    step();
    mem_resp = 0; d_pmem_read = 0;
    step();

    // Randomized traffic, including illegal D read+write and stray responses.
    lat = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) i_pmem_read = !i_pmem_read;
      i_pmem_address = $urandom;
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(4))
          1: begin d_pmem_read = 1; d_pmem_write = 0; end
          2: begin d_pmem_read = 0; d_pmem_write = 1; end
          3: begin d_pmem_read = 1; d_pmem_write = 1; end
          default: begin d_pmem_read = 0; d_pmem_write = 0; end
        endcase
      end
      d_pmem_address = $urandom;
      d_pmem_wdata = rnd_line();
      mem_rdata = rnd_line();
      if (m_busy) begin
        if (lat == 0) begin
          mem_resp = 1;
          lat = $urandom_range(3);
        end else begin
          mem_resp = 0;
          lat--;
        end
      end else begin
        mem_resp = ($urandom_range(7) == 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
